// File: rtl/multicycle_controller_if.sv
// Control bundle between the multicycle controller and its datapath.
// The controller takes the master side; the datapath (or a bench) takes the slave side.
interface multicycle_controller_if #(
    parameter int CNT_W = 32
);
    logic [31:0]      IReg_out;
    logic             zero;
    logic             PCWrite;
    logic             PCWriteCond;
    logic             IorD;
    logic             MemRead;
    logic             MemWrite;
    logic             IRWrite;
    logic             MemtoReg;
    logic             ALUSrcA;
    logic             RegWrite;
    logic             RegDst;
    logic [1:0]       PCSource;
    logic [1:0]       ALUSrcB;
    logic [3:0]       ALUOp;
    logic             halted;
    logic             illegal;
    logic [CNT_W-1:0] instr_count;

    modport master (
        input  IReg_out, zero,
        output PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
               MemtoReg, ALUSrcA, RegWrite, RegDst, PCSource, ALUSrcB,
               ALUOp, halted, illegal, instr_count
    );

    modport slave (
        output IReg_out, zero,
        input  PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
               MemtoReg, ALUSrcA, RegWrite, RegDst, PCSource, ALUSrcB,
               ALUOp, halted, illegal, instr_count
    );
endinterface

// File: rtl/multicycle_controller.sv
// Moore FSM sequencing the multicycle CPU datapath, with halt status and retired-instruction count.
// Define CTRL_ILLEGAL_TRAP_EN to trap illegal opcodes into HALT; otherwise they retire as NOP.
module multicycle_controller #(
    parameter int CNT_W = 32
) (
    input  logic                    clk,
    input  logic                    reset,
    multicycle_controller_if.master bus
);

    // state  | meaning
    // RST    | post-reset idle cycle          FETCH  | read instr, PC += 1
    // DECODE | branch target into ALUOut      EXEC_R | reg-reg ALU op
    // EXEC_I | reg-imm ALU op                 ALU_WB | write ALU result
    // MEM_RD | load read                      MEM_WB | write load data
    // MEM_WR | store write                    BRANCH | compare, cond PC write
    // JUMP   | PC <= jump target              HALT   | parked until reset
    typedef enum logic [3:0] {
        ST_RST,
        ST_FETCH,
        ST_DECODE,
        ST_EXEC_R,
        ST_EXEC_I,
        ST_ALU_WB,
        ST_MEM_RD,
        ST_MEM_WB,
        ST_MEM_WR,
        ST_BRANCH,
        ST_JUMP,
        ST_HALT
    } state_t;

    localparam logic [5:0] OP_NOP  = 6'b000000;
    localparam logic [5:0] OP_RALU = 6'b000001;
    localparam logic [5:0] OP_ADDI = 6'b000010;
    localparam logic [5:0] OP_ORI  = 6'b000011;
    localparam logic [5:0] OP_LW   = 6'b000100;
    localparam logic [5:0] OP_SW   = 6'b000101;
    localparam logic [5:0] OP_BEQ  = 6'b000110;
    localparam logic [5:0] OP_J    = 6'b000111;
    localparam logic [5:0] OP_HALT = 6'b111111;

    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b0001;
    localparam logic [3:0] ALU_OR  = 4'b0011;

    localparam logic [1:0] SRCB_REG  = 2'b00;
    localparam logic [1:0] SRCB_ONE  = 2'b01;
    localparam logic [1:0] SRCB_SEXT = 2'b10;
    localparam logic [1:0] SRCB_ZEXT = 2'b11;

    localparam logic [1:0] PCSRC_ALU  = 2'b00;
    localparam logic [1:0] PCSRC_OUT  = 2'b01;
    localparam logic [1:0] PCSRC_JUMP = 2'b10;

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] count;
    logic             count_en;
    logic [5:0]       opcode;
    logic [3:0]       funct;

    logic             pc_write;
    logic             pc_write_cond;
    logic             mem_read;
    logic             mem_write;
    logic             ir_write;
    logic             mem_to_reg;
    logic             alu_src_a;
    logic             reg_write;
    logic [1:0]       pc_source;
    logic [1:0]       alu_src_b;
    logic [3:0]       alu_op;
    logic             halt_flag;

    assign opcode = bus.IReg_out[31:26];
    assign funct  = bus.IReg_out[3:0];

    // The controller is purely Moore on the branch flag; the datapath samples zero itself.
    logic unused_inputs;
    assign unused_inputs = ^{bus.IReg_out[25:4], bus.zero};

`ifdef CTRL_ILLEGAL_TRAP_EN
    logic illegal_set;
    logic illegal_q;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_RST;
            count <= '0;
        end else begin
            state <= state_nxt;
            if (count_en) begin
                count <= count + CNT_W'(1);
            end
        end
    end

`ifdef CTRL_ILLEGAL_TRAP_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            illegal_q <= 1'b0;
        end else if (illegal_set) begin
            illegal_q <= 1'b1;
        end
    end
`endif

    always_comb begin
        state_nxt     = state;
        count_en      = 1'b0;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        mem_to_reg    = 1'b0;
        alu_src_a     = 1'b0;
        reg_write     = 1'b0;
        pc_source     = PCSRC_ALU;
        alu_src_b     = SRCB_REG;
        alu_op        = ALU_ADD;
        halt_flag     = 1'b0;
`ifdef CTRL_ILLEGAL_TRAP_EN
        illegal_set   = 1'b0;
`endif

        case (state)
            ST_RST: begin
                state_nxt = ST_FETCH;
            end
            ST_FETCH: begin
                mem_read  = 1'b1;
                ir_write  = 1'b1;
                alu_src_b = SRCB_ONE;
                pc_write  = 1'b1;
                state_nxt = ST_DECODE;
            end
            ST_DECODE: begin
                alu_src_b = SRCB_SEXT;
                case (opcode)
                    OP_NOP: begin
                        state_nxt = ST_FETCH;
                        count_en  = 1'b1;
                    end
                    OP_RALU:        state_nxt = ST_EXEC_R;
                    OP_ADDI, OP_ORI: state_nxt = ST_EXEC_I;
                    OP_LW:          state_nxt = ST_MEM_RD;
                    OP_SW:          state_nxt = ST_MEM_WR;
                    OP_BEQ:         state_nxt = ST_BRANCH;
                    OP_J:           state_nxt = ST_JUMP;
                    OP_HALT: begin
                        state_nxt = ST_HALT;
                        count_en  = 1'b1;
                    end
                    default: begin
`ifdef CTRL_ILLEGAL_TRAP_EN
                        state_nxt   = ST_HALT;
                        illegal_set = 1'b1;
`else
                        state_nxt   = ST_FETCH;
                        count_en    = 1'b1;
`endif
                    end
                endcase
            end
            ST_EXEC_R: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_REG;
                alu_op    = funct;
                state_nxt = ST_ALU_WB;
            end
            ST_EXEC_I: begin
                alu_src_a = 1'b1;
                if (opcode == OP_ORI) begin
                    alu_src_b = SRCB_ZEXT;
                    alu_op    = ALU_OR;
                end else begin
                    alu_src_b = SRCB_SEXT;
                    alu_op    = ALU_ADD;
                end
                state_nxt = ST_ALU_WB;
            end
            ST_ALU_WB: begin
                reg_write = 1'b1;
                state_nxt = ST_FETCH;
                count_en  = 1'b1;
            end
            ST_MEM_RD: begin
                mem_read  = 1'b1;
                state_nxt = ST_MEM_WB;
            end
            ST_MEM_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                state_nxt  = ST_FETCH;
                count_en   = 1'b1;
            end
            ST_MEM_WR: begin
                mem_write = 1'b1;
                state_nxt = ST_FETCH;
                count_en  = 1'b1;
            end
            ST_BRANCH: begin
                alu_src_a     = 1'b1;
                alu_src_b     = SRCB_REG;
                alu_op        = ALU_SUB;
                pc_write_cond = 1'b1;
                pc_source     = PCSRC_OUT;
                state_nxt     = ST_FETCH;
                count_en      = 1'b1;
            end
            ST_JUMP: begin
                pc_write  = 1'b1;
                pc_source = PCSRC_JUMP;
                state_nxt = ST_FETCH;
                count_en  = 1'b1;
            end
            ST_HALT: begin
                halt_flag = 1'b1;
                state_nxt = ST_HALT;
            end
            default: begin
                state_nxt = ST_RST;
            end
        endcase
    end

    assign bus.PCWrite     = pc_write;
    assign bus.PCWriteCond = pc_write_cond;
    assign bus.IorD        = 1'b0;
    assign bus.MemRead     = mem_read;
    assign bus.MemWrite    = mem_write;
    assign bus.IRWrite     = ir_write;
    assign bus.MemtoReg    = mem_to_reg;
    assign bus.ALUSrcA     = alu_src_a;
    assign bus.RegWrite    = reg_write;
    assign bus.RegDst      = 1'b0;
    assign bus.PCSource    = pc_source;
    assign bus.ALUSrcB     = alu_src_b;
    assign bus.ALUOp       = alu_op;
    assign bus.halted      = halt_flag;
    assign bus.instr_count = count;
`ifdef CTRL_ILLEGAL_TRAP_EN
    assign bus.illegal     = illegal_q;
`else
    assign bus.illegal     = 1'b0;
`endif

endmodule

// File: tb/tb_multicycle_controller.sv
// Scoreboard bench for multicycle_controller: per-cycle expected control vectors are queued
// when an instruction is issued and compared against the DUT on each falling edge.
module tb_multicycle_controller;

    localparam int CNT_W = 32;

    localparam logic [5:0] OP_NOP  = 6'b000000;
    localparam logic [5:0] OP_RALU = 6'b000001;
    localparam logic [5:0] OP_ADDI = 6'b000010;
    localparam logic [5:0] OP_ORI  = 6'b000011;
    localparam logic [5:0] OP_LW   = 6'b000100;
    localparam logic [5:0] OP_SW   = 6'b000101;
    localparam logic [5:0] OP_BEQ  = 6'b000110;
    localparam logic [5:0] OP_J    = 6'b000111;
    localparam logic [5:0] OP_HALT = 6'b111111;
    localparam logic [5:0] OP_BAD  = 6'b101010;

    typedef enum {T_RST, T_FETCH, T_DECODE, T_EXEC_R, T_EXEC_I, T_ALU_WB,
                  T_MEM_RD, T_MEM_WB, T_MEM_WR, T_BRANCH, T_JUMP, T_HALT} tstate_t;

    typedef struct {
        string            tag;
        logic [19:0]      ctrl;
        logic [CNT_W-1:0] cnt;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    multicycle_controller_if #(.CNT_W(CNT_W)) bus ();

    multicycle_controller #(.CNT_W(CNT_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    exp_t             exp_q[$];
    int               n_checks = 0;
    int               n_fail   = 0;
    logic [CNT_W-1:0] model_count;
    logic             model_illegal;
    logic [5:0]       cur_op;
    logic [3:0]       cur_fn;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // {PCWrite,PCWriteCond,IorD,MemRead,MemWrite,IRWrite,MemtoReg,ALUSrcA,RegWrite,RegDst,
    //  PCSource[1:0],ALUSrcB[1:0],ALUOp[3:0],halted,illegal}
    function automatic logic [19:0] ctrl_for(tstate_t s, logic [5:0] op, logic [3:0] fn, logic ill);
        logic pcw, pcwc, mrd, mwr, irw, m2r, srca, rw, hlt;
        logic [1:0] pcs, srcb;
        logic [3:0] aop;
        {pcw, pcwc, mrd, mwr, irw, m2r, srca, rw, hlt} = '0;
        pcs = 2'b00; srcb = 2'b00; aop = 4'b0000;
        case (s)
            T_FETCH:  begin mrd = 1; irw = 1; srcb = 2'b01; pcw = 1; end
            T_DECODE: srcb = 2'b10;
            T_EXEC_R: begin srca = 1; aop = fn; end
            T_EXEC_I: begin
                srca = 1;
                if (op == OP_ORI) begin srcb = 2'b11; aop = 4'b0011; end
                else              begin srcb = 2'b10; aop = 4'b0000; end
            end
            T_ALU_WB: rw = 1;
            T_MEM_RD: mrd = 1;
            T_MEM_WB: begin rw = 1; m2r = 1; end
            T_MEM_WR: mwr = 1;
            T_BRANCH: begin srca = 1; aop = 4'b0001; pcwc = 1; pcs = 2'b01; end
            T_JUMP:   begin pcw = 1; pcs = 2'b10; end
            T_HALT:   hlt = 1;
            default:  ;
        endcase
        return {pcw, pcwc, 1'b0, mrd, mwr, irw, m2r, srca, rw, 1'b0, pcs, srcb, aop, hlt, ill};
    endfunction

    task automatic push_exp(input tstate_t s, input string tag);
        exp_t e;
        e.tag  = $sformatf("%s/%s", tag, s.name());
        e.ctrl = ctrl_for(s, cur_op, cur_fn, model_illegal);
        e.cnt  = model_count;
        exp_q.push_back(e);
    endtask

    always @(negedge clk) begin
        exp_t e;
        logic [19:0] got;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            got = {bus.PCWrite, bus.PCWriteCond, bus.IorD, bus.MemRead, bus.MemWrite,
                   bus.IRWrite, bus.MemtoReg, bus.ALUSrcA, bus.RegWrite, bus.RegDst,
                   bus.PCSource, bus.ALUSrcB, bus.ALUOp, bus.halted, bus.illegal};
            check_val({e.tag, ".ctrl"}, 64'(got), 64'(e.ctrl));
            check_val({e.tag, ".count"}, 64'(bus.instr_count), 64'(e.cnt));
        end
    end

    // Entered at posedge+1 with the current cycle's expectation already queued (if push_cur=0).
    // Leaves at posedge+1 of the first FETCH cycle, nothing queued for it yet.
    task automatic do_reset(input int n, input bit push_cur, input tstate_t cur, input string tag);
        if (push_cur) push_exp(cur, tag);
        reset = 1'b1;
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            model_count   = '0;
            model_illegal = 1'b0;
            if (i == n - 1) reset = 1'b0;
            push_exp(T_RST, {tag, "_rst"});
        end
        @(posedge clk); #1;
    endtask

    // Entered at posedge+1 in FETCH; leaves at posedge+1 of the cycle after the instruction.
    task automatic run_instr(input logic [5:0] op, input logic [3:0] fn, input logic zero_v,
                             input string tag);
        tstate_t seq[$];
        cur_op = op;
        cur_fn = fn;
        bus.IReg_out = {op, 22'($urandom), fn};
        bus.zero     = zero_v;
        seq = {T_FETCH, T_DECODE};
        case (op)
            OP_NOP:          ;
            OP_RALU:         begin seq.push_back(T_EXEC_R); seq.push_back(T_ALU_WB); end
            OP_ADDI, OP_ORI: begin seq.push_back(T_EXEC_I); seq.push_back(T_ALU_WB); end
            OP_LW:           begin seq.push_back(T_MEM_RD); seq.push_back(T_MEM_WB); end
            OP_SW:           seq.push_back(T_MEM_WR);
            OP_BEQ:          seq.push_back(T_BRANCH);
            OP_J:            seq.push_back(T_JUMP);
            OP_HALT:         seq.push_back(T_HALT);
            default: begin
`ifdef CTRL_ILLEGAL_TRAP_EN
                seq.push_back(T_HALT);
`endif
            end
        endcase
        foreach (seq[i]) begin
            if (seq[i] == T_HALT) begin
                if (op == OP_HALT) model_count = model_count + 1;
                else               model_illegal = 1'b1;
            end
            push_exp(seq[i], tag);
        end
        if (seq[seq.size() - 1] != T_HALT) model_count = model_count + 1;
        repeat (seq.size()) @(posedge clk);
        #1;
    endtask

    task automatic hold_halt(input int n, input string tag);
        for (int i = 0; i < n; i++) begin
            push_exp(T_HALT, tag);
            @(posedge clk); #1;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.IReg_out  = '0;
        bus.zero      = 1'b0;
        model_count   = '0;
        model_illegal = 1'b0;
        cur_op        = OP_NOP;
        cur_fn        = 4'h0;

        do_reset(3, 1'b0, T_RST, "init");

        run_instr(OP_RALU, 4'h1, 1'b0, "ralu_sub");
        run_instr(OP_LW,   4'h0, 1'b0, "lw");
        run_instr(OP_SW,   4'h0, 1'b0, "sw");
        run_instr(OP_BEQ,  4'h0, 1'b1, "beq_z1");
        run_instr(OP_BEQ,  4'h0, 1'b0, "beq_z0");
        run_instr(OP_ADDI, 4'h5, 1'b0, "addi");
        run_instr(OP_ORI,  4'h9, 1'b1, "ori");
        run_instr(OP_J,    4'h0, 1'b0, "jump");
        run_instr(OP_NOP,  4'h0, 1'b0, "nop");
        run_instr(OP_RALU, 4'h4, 1'b0, "ralu_xor");
        run_instr(OP_RALU, 4'h2, 1'b1, "ralu_and");
        run_instr(OP_BAD,  4'h3, 1'b0, "illegal");
`ifdef CTRL_ILLEGAL_TRAP_EN
        hold_halt(20, "illegal_hold");
        do_reset(1, 1'b1, T_HALT, "illegal_clr");
`endif
        run_instr(OP_ADDI, 4'h1, 1'b0, "addi2");
        run_instr(OP_HALT, 4'h0, 1'b0, "halt");
        hold_halt(6, "halt_hold");
        do_reset(1, 1'b1, T_HALT, "halt_rst");

        run_instr(OP_NOP, 4'h0, 1'b0, "nop2");
        // LW abandoned in MEM_RD: no MEM_WB strobe, count back to zero.
        cur_op = OP_LW;
        cur_fn = 4'h0;
        bus.IReg_out = {OP_LW, 22'h0, 4'h0};
        push_exp(T_FETCH, "lw_abort");
        push_exp(T_DECODE, "lw_abort");
        repeat (2) @(posedge clk);
        #1;
        do_reset(1, 1'b1, T_MEM_RD, "lw_abort");

        run_instr(OP_NOP, 4'h0, 1'b0, "nop3");
        cur_op = OP_NOP;
        push_exp(T_FETCH, "final");
        @(posedge clk); #1;
        check_val("queue_drained", 64'(exp_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
